// File: rtl/state_mem_pkg.sv
// rtl/state_mem_pkg.sv - shared types and default sizing for the FPU state-memory register bank
//
// Purpose : load-engine state encoding plus the default register/datapath geometry
//           used by the FPU top when instantiating state_reg_bank.
// Ports   : none (package).
package state_mem_pkg;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_WAIT = 1'b1
    } ld_state_t;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_SRC  = 6;
    localparam int DEF_NUM_RD   = 2;

endpackage

// File: rtl/state_reg_bank_src_select_mux.sv
// rtl/state_reg_bank_src_select_mux.sv - per-register datapath source select
//
// Purpose : picks one of NUM_SRC datapath results for a single register.
//           An out-of-range select yields hold_data and drops valid_sel.
// Ports   : sel        in  SRC_W            source index
//           src_data   in  NUM_SRC*DATA_W   datapath results, source k at [k*DATA_W +: DATA_W]
//           hold_data  in  DATA_W           current register value
//           out_data   out DATA_W           selected source, or hold_data when sel is illegal
//           valid_sel  out 1                sel < NUM_SRC
module src_select_mux #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 6,
    localparam int SRC_W  = $clog2(NUM_SRC + 1)
) (
    input  logic [SRC_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]         hold_data,
    output logic [DATA_W-1:0]         out_data,
    output logic                      valid_sel
);

    // Decoded compare rather than a direct index so that an illegal select
    // never reads beyond the packed source vector.
    always_comb begin
        out_data  = hold_data;
        valid_sel = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SRC_W'(k)) begin
                out_data  = src_data[k*DATA_W +: DATA_W];
                valid_sel = 1'b1;
            end
        end
    end

endmodule

// File: rtl/state_reg_bank.sv
// rtl/state_reg_bank.sv - FPU state-memory register bank with per-register source select and SRAM load engine
//
// Purpose : NUM_REGS registers, each with its own write enable and source select,
//           a single-outstanding SRAM load engine with per-register busy tracking,
//           and NUM_RD combinational read ports.
// Macro   : STATE_MEM_BYPASS_EN - when defined, read ports forward the value being
//           written this cycle (datapath first, then a non-cancelled SRAM return).
// Ports   : clk, rst (sync, active high)
//           src_data, wr_en, wr_sel          datapath write side
//           ld_req, ld_dst, ld_ready         load request side
//           sram_valid, sram_data            load return side
//           rd_addr, rd_data                 read ports
//           busy, err_sel, err_waw           status
module state_reg_bank
    import state_mem_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int NUM_RD   = DEF_NUM_RD,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int SRC_W   = $clog2(NUM_SRC + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*DATA_W-1:0]  src_data,
    input  logic [NUM_REGS-1:0]        wr_en,
    input  logic [NUM_REGS*SRC_W-1:0]  wr_sel,
    input  logic                       ld_req,
    input  logic [REG_W-1:0]           ld_dst,
    output logic                       ld_ready,
    input  logic                       sram_valid,
    input  logic [DATA_W-1:0]          sram_data,
    input  logic [NUM_RD*REG_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_REGS-1:0]        busy,
    output logic                       err_sel,
    output logic                       err_waw
);

    ld_state_t            state, state_nx;
    logic [REG_W-1:0]     dst_q;
    logic                 cancel_q;
    logic [NUM_REGS-1:0]  busy_q;
    logic                 err_sel_q, err_waw_q;
    logic [DATA_W-1:0]    regs   [NUM_REGS];
    logic [DATA_W-1:0]    dp_val [NUM_REGS];
    logic [DATA_W-1:0]    nx_val [NUM_REGS];
    logic [NUM_REGS-1:0]  valid_sel;
    logic [NUM_REGS-1:0]  dp_wr;
    logic [NUM_REGS-1:0]  wr_now;
    logic                 accept, ret, waw;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_mux
        src_select_mux #(
            .DATA_W  (DATA_W),
            .NUM_SRC (NUM_SRC)
        ) u_mux (
            .sel       (wr_sel[r*SRC_W +: SRC_W]),
            .src_data  (src_data),
            .hold_data (regs[r]),
            .out_data  (dp_val[r]),
            .valid_sel (valid_sel[r])
        );
    end

    assign dp_wr = wr_en & valid_sel;

    // Load engine next state and handshake strobes.
    always_comb begin
        accept   = (state == LD_IDLE) && ld_req;
        ret      = (state == LD_WAIT) && sram_valid;
        waw      = (state == LD_WAIT) && dp_wr[dst_q];
        state_nx = state;
        case (state)
            LD_IDLE: if (ld_req)     state_nx = LD_WAIT;
            LD_WAIT: if (sram_valid) state_nx = LD_IDLE;
            default:                 state_nx = LD_IDLE;
        endcase
    end

    // Per-register next value: datapath wins; an SRAM return lands only when
    // nothing cancelled it. Shared by the register update and the bypass path.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_now[r] = dp_wr[r];
            nx_val[r] = dp_val[r];
            if (!dp_wr[r] && ret && !cancel_q && (dst_q == REG_W'(r))) begin
                wr_now[r] = 1'b1;
                nx_val[r] = sram_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LD_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy_q    <= '0;
            dst_q     <= '0;
            cancel_q  <= 1'b0;
            err_sel_q <= 1'b0;
            err_waw_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_now[r]) regs[r] <= nx_val[r];
            end
            if (accept) begin
                dst_q          <= ld_dst;
                cancel_q       <= 1'b0;
                busy_q[ld_dst] <= 1'b1;
            end else if (waw) begin
                cancel_q <= 1'b1;
            end
            // busy only clears on the return, even for a cancelled load.
            if (ret) busy_q[dst_q] <= 1'b0;
            err_sel_q <= |(wr_en & ~valid_sel);
            err_waw_q <= waw;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
`ifdef STATE_MEM_BYPASS_EN
            rd_data[p*DATA_W +: DATA_W] = wr_now[rd_addr[p*REG_W +: REG_W]]
                                        ? nx_val[rd_addr[p*REG_W +: REG_W]]
                                        : regs[rd_addr[p*REG_W +: REG_W]];
`else
            rd_data[p*DATA_W +: DATA_W] = regs[rd_addr[p*REG_W +: REG_W]];
`endif
        end
    end

    assign ld_ready = (state == LD_IDLE);
    assign busy     = busy_q;
    assign err_sel  = err_sel_q;
    assign err_waw  = err_waw_q;

endmodule

// File: tb/tb_state_reg_bank.sv
// tb/tb_state_reg_bank.sv - directed self-checking bench for state_reg_bank
module tb_state_reg_bank;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int NUM_SRC  = 6;
    localparam int NUM_RD   = 2;
    localparam int REG_W    = 4;
    localparam int SRC_W    = 3;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SRC*DATA_W-1:0]  src_data;
    logic [NUM_REGS-1:0]        wr_en;
    logic [NUM_REGS*SRC_W-1:0]  wr_sel;
    logic                       ld_req;
    logic [REG_W-1:0]           ld_dst;
    logic                       ld_ready;
    logic                       sram_valid;
    logic [DATA_W-1:0]          sram_data;
    logic [NUM_RD*REG_W-1:0]    rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_REGS-1:0]        busy;
    logic                       err_sel;
    logic                       err_waw;

    int checks   = 0;
    int failures = 0;

    state_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .NUM_SRC  (NUM_SRC),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_data   (src_data),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .ld_req     (ld_req),
        .ld_dst     (ld_dst),
        .ld_ready   (ld_ready),
        .sram_valid (sram_valid),
        .sram_data  (sram_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .err_sel    (err_sel),
        .err_waw    (err_waw)
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reads register r on port 0 and register rb on port 1.
    task automatic chk_rd(input string tag, input int r, input logic [31:0] exp,
                          input int rb, input logic [31:0] expb);
        rd_addr[3:0] = REG_W'(r);
        rd_addr[7:4] = REG_W'(rb);
        #1;
        chk({tag, "_p0"}, 64'(rd_data[31:0]), 64'(exp));
        chk({tag, "_p1"}, 64'(rd_data[63:32]), 64'(expb));
    endtask

    task automatic set_sel(input int r, input int s);
        wr_sel[r*SRC_W +: SRC_W] = SRC_W'(s);
    endtask

    task automatic set_src(input int k, input logic [31:0] v);
        src_data[k*DATA_W +: DATA_W] = v;
    endtask

    logic [31:0] byp;

    initial begin
        rst = 1'b1; src_data = '0; wr_en = '0; wr_sel = '0;
        ld_req = 1'b0; ld_dst = '0; sram_valid = 1'b0; sram_data = '0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;

        // 1: reset state
        for (int r = 0; r < NUM_REGS; r++) chk_rd("t1_reg", r, 32'h0, 15 - r, 32'h0);
        chk("t1_busy", 64'(busy), 64'h0);
        chk("t1_ld_ready", 64'(ld_ready), 64'h1);
        chk("t1_err_sel", 64'(err_sel), 64'h0);
        chk("t1_err_waw", 64'(err_waw), 64'h0);

        // 2: two registers written in the same cycle from different sources
        set_src(2, 32'h3F800000);
        set_src(5, 32'hC0000000);
        set_sel(0, 2);
        set_sel(3, 5);
        wr_en = 16'h0009;
`ifdef STATE_MEM_BYPASS_EN
        chk_rd("t2_same_cycle", 0, 32'h3F800000, 3, 32'hC0000000);
`else
        chk_rd("t2_same_cycle", 0, 32'h0, 3, 32'h0);
`endif
        tick();
        wr_en = '0;
        chk_rd("t2_written", 0, 32'h3F800000, 3, 32'hC0000000);
        chk_rd("t2_others", 1, 32'h0, 2, 32'h0);
        chk_rd("t2_others_hi", 4, 32'h0, 15, 32'h0);
        chk("t2_err_sel", 64'(err_sel), 64'h0);

        // 3: load into r7, return three cycles after acceptance
        ld_dst = 4'd7; ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("t3_busy_c1", 64'(busy), 64'h0080);
        chk("t3_ld_ready_wait", 64'(ld_ready), 64'h0);
        tick();
        ld_req = 1'b1; ld_dst = 4'd2;   // ignored while a load is outstanding
        chk("t3_busy_c2", 64'(busy), 64'h0080);
        tick();
        ld_req = 1'b0;
        chk("t3_busy_c3", 64'(busy), 64'h0080);
        sram_valid = 1'b1; sram_data = 32'h40490FDB;
`ifdef STATE_MEM_BYPASS_EN
        byp = 32'h40490FDB;
`else
        byp = 32'h0;
`endif
        chk_rd("t3_ret_cycle", 7, byp, 2, 32'h0);
        tick();
        sram_valid = 1'b0;
        chk_rd("t3_loaded", 7, 32'h40490FDB, 2, 32'h0);
        chk("t3_busy_clear", 64'(busy), 64'h0);
        chk("t3_ld_ready", 64'(ld_ready), 64'h1);

        // 4: WAW cancels the load into r4
        ld_dst = 4'd4; ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("t4_busy", 64'(busy), 64'h0010);
        set_src(0, 32'h11111111);
        set_sel(4, 0);
        wr_en = 16'h0010;
        tick();
        wr_en = '0;
        chk_rd("t4_dp_write", 4, 32'h11111111, 7, 32'h40490FDB);
        chk("t4_err_waw_pulse", 64'(err_waw), 64'h1);
        chk("t4_busy_held", 64'(busy), 64'h0010);
        sram_valid = 1'b1; sram_data = 32'h22222222;
        chk_rd("t4_no_fwd_discard", 4, 32'h11111111, 0, 32'h3F800000);
        tick();
        sram_valid = 1'b0;
        chk_rd("t4_discarded", 4, 32'h11111111, 3, 32'hC0000000);
        chk("t4_err_waw_once", 64'(err_waw), 64'h0);
        chk("t4_busy_clear", 64'(busy), 64'h0);
        chk("t4_ld_ready", 64'(ld_ready), 64'h1);

        // 5: illegal select leaves r9 untouched
        set_src(1, 32'hA5A5A5A5);
        set_sel(9, 1);
        wr_en = 16'h0200;
        tick();
        chk_rd("t5_legal_pre", 9, 32'hA5A5A5A5, 0, 32'h3F800000);
        set_src(1, 32'h5A5A5A5A);
        set_sel(9, 6);
        tick();
        wr_en = '0;
        chk_rd("t5_unchanged", 9, 32'hA5A5A5A5, 4, 32'h11111111);
        chk("t5_err_sel_pulse", 64'(err_sel), 64'h1);
        tick();
        chk("t5_err_sel_single", 64'(err_sel), 64'h0);

        // Same-cycle sram return and datapath write to the load target
        ld_dst = 4'd5; ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        set_src(0, 32'h0BADF00D);
        set_sel(5, 0);
        wr_en = 16'h0020;
        sram_valid = 1'b1; sram_data = 32'hFEEDFACE;
        tick();
        wr_en = '0; sram_valid = 1'b0;
        chk_rd("tx_dp_wins", 5, 32'h0BADF00D, 9, 32'hA5A5A5A5);
        chk("tx_err_waw", 64'(err_waw), 64'h1);
        chk("tx_busy_clear", 64'(busy), 64'h0);

        // 6: reset during WAIT, then a stray return
        ld_dst = 4'd7; ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
        chk("t6_busy_wait", 64'(busy), 64'h0080);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_busy_reset", 64'(busy), 64'h0);
        chk("t6_ld_ready_reset", 64'(ld_ready), 64'h1);
        sram_valid = 1'b1; sram_data = 32'hDEADBEEF;
        tick();
        sram_valid = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) chk_rd("t6_reg", r, 32'h0, 7, 32'h0);
        chk("t6_busy_after", 64'(busy), 64'h0);
        chk("t6_ld_ready_after", 64'(ld_ready), 64'h1);
        chk("t6_err_sel", 64'(err_sel), 64'h0);
        chk("t6_err_waw", 64'(err_waw), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
